// File: rtl/ila_pkg.sv
// Shared definitions for the ILA UART command path: ASCII constants, FSM
// state encodings, baud divider and hex-digit decode.
package ila_pkg;

  localparam logic [7:0] ASCII_SP = 8'h20;
  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  typedef enum logic [2:0] {
    R_IDLE,
    R_START,
    R_DATA,
    R_STOP,
    R_BREAK
  } rx_state_e;

  typedef enum logic [1:0] {
    P_ADDR,
    P_DATA,
    P_SKIP
  } parse_state_e;

  // Clocks per bit; the TX side uses the same formula.
  function automatic int unsigned clk_div(input int unsigned freq, input int unsigned baud);
    return freq / baud;
  endfunction

  // Returns {valid, nibble} for '0'-'9', 'a'-'f', 'A'-'F'.
  function automatic logic [4:0] hex_decode(input logic [7:0] c);
    logic [4:0] r;
    r = '0;
    if (c >= 8'h30 && c <= 8'h39)
      r = {1'b1, c[3:0]};
    else if ((c >= 8'h61 && c <= 8'h66) || (c >= 8'h41 && c <= 8'h46))
      r = {1'b1, c[3:0] + 4'd9};
    return r;
  endfunction

endpackage

// File: rtl/ila_uart_rx_byte.sv
// UART 8N1 byte receiver: 2-FF synchroniser and RX FSM producing one-cycle
// byte and framing-error strobes.
module ila_uart_rx_byte
  import ila_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 74250000,
  parameter int unsigned BAUD     = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd_i,
  output logic [7:0] rx_byte_o,
  output logic       rx_strb_o,
  output logic       rx_ferr_o
);

  localparam int unsigned CLK_DIV = clk_div(CLK_FREQ, BAUD);
  localparam int unsigned CW      = $clog2(CLK_DIV + 1);
  localparam int unsigned HALF    = CLK_DIV / 2;

  rx_state_e      state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [2:0]     bit_q, bit_d;
  logic [7:0]     sh_q, sh_d;
  logic           meta_q, sync_q;
  logic           strb_q, strb_d;
  logic           ferr_q, ferr_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q  <= 1'b1;
      sync_q  <= 1'b1;
      state_q <= R_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      strb_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      meta_q  <= rxd_i;
      sync_q  <= meta_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      strb_q  <= strb_d;
      ferr_q  <= ferr_d;
    end
  end

  // The counter is cleared to 0 on each event, so matching CLK_DIV-1 keeps
  // sample points exactly CLK_DIV clocks apart from mid-start onwards.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    bit_d   = bit_q;
    sh_d    = sh_q;
    strb_d  = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      R_IDLE: begin
        cnt_d = '0;
        if (!sync_q) state_d = R_START;
      end
      R_START: begin
        if (cnt_q == CW'(HALF - 1)) begin
          cnt_d = '0;
          if (!sync_q) begin
            state_d = R_DATA;
            bit_d   = '0;
          end else begin
            state_d = R_IDLE;
          end
        end
      end
      R_DATA: begin
        if (cnt_q == CW'(CLK_DIV - 1)) begin
          cnt_d = '0;
          sh_d  = {sync_q, sh_q[7:1]};
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = R_STOP;
        end
      end
      R_STOP: begin
        if (cnt_q == CW'(CLK_DIV - 1)) begin
          cnt_d = '0;
          if (sync_q) begin
            strb_d  = 1'b1;
            state_d = R_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = R_BREAK;
          end
        end
      end
      R_BREAK: begin
        cnt_d = '0;
        if (sync_q) state_d = R_IDLE;
      end
      default: state_d = R_IDLE;
    endcase
  end

  assign rx_byte_o = sh_q;
  assign rx_strb_o = strb_q;
  assign rx_ferr_o = ferr_q;

endmodule

// File: rtl/ila_uart_cmd_rx.sv
// UART ASCII hex command parser: "<addr> <data>\r" produces one register
// write strobe; framing and syntax errors pulse o_err.
module ila_uart_cmd_rx
  import ila_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 74250000,
  parameter int unsigned BAUD     = 115200,
  parameter int unsigned AW       = 8,
  parameter int unsigned DW       = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_rxd,
  output logic          o_wr_strb,
  output logic [AW-1:0] o_wr_addr,
  output logic [DW-1:0] o_wr_data,
  output logic          o_err
);

  logic [7:0] rx_byte;
  logic       rx_strb;
  logic       rx_ferr;

  ila_uart_rx_byte #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD     (BAUD)
  ) u_rx (
    .clk       (clk),
    .rst       (rst),
    .rxd_i     (i_rxd),
    .rx_byte_o (rx_byte),
    .rx_strb_o (rx_strb),
    .rx_ferr_o (rx_ferr)
  );

  parse_state_e  pstate_q, pstate_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] data_q, data_d;
  logic          ndig_q, ndig_d;
  logic          strb_q, strb_d;
  logic          err_q, err_d;
  logic [AW-1:0] wa_q, wa_d;
  logic [DW-1:0] wd_q, wd_d;

  logic [4:0] hex;
  logic       is_eol;
  logic       is_sp;

  assign hex    = hex_decode(rx_byte);
  assign is_eol = (rx_byte == ASCII_CR) || (rx_byte == ASCII_LF);
  assign is_sp  = (rx_byte == ASCII_SP);

  always_ff @(posedge clk) begin
    if (rst) begin
      pstate_q <= P_ADDR;
      addr_q   <= '0;
      data_q   <= '0;
      ndig_q   <= 1'b0;
      strb_q   <= 1'b0;
      err_q    <= 1'b0;
      wa_q     <= '0;
      wd_q     <= '0;
    end else begin
      pstate_q <= pstate_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      ndig_q   <= ndig_d;
      strb_q   <= strb_d;
      err_q    <= err_d;
      wa_q     <= wa_d;
      wd_q     <= wd_d;
    end
  end

  always_comb begin
    pstate_d = pstate_q;
    addr_d   = addr_q;
    data_d   = data_q;
    ndig_d   = ndig_q;
    strb_d   = 1'b0;
    err_d    = 1'b0;
    wa_d     = wa_q;
    wd_d     = wd_q;
    if (rx_ferr) begin
      err_d    = 1'b1;
      pstate_d = P_SKIP;
    end else if (rx_strb) begin
      case (pstate_q)
        P_ADDR: begin
          if (hex[4]) begin
            addr_d = AW'({addr_q, hex[3:0]});
            ndig_d = 1'b1;
          end else if (is_sp && ndig_q) begin
            pstate_d = P_DATA;
            data_d   = '0;
            ndig_d   = 1'b0;
          end else if (!(is_eol && !ndig_q)) begin
            err_d    = 1'b1;
            pstate_d = P_SKIP;
          end
        end
        P_DATA: begin
          if (hex[4]) begin
            data_d = DW'({data_q, hex[3:0]});
            ndig_d = 1'b1;
          end else if (is_eol && ndig_q) begin
            strb_d   = 1'b1;
            wa_d     = addr_q;
            wd_d     = data_q;
            pstate_d = P_ADDR;
            addr_d   = '0;
            ndig_d   = 1'b0;
          end else begin
            err_d    = 1'b1;
            pstate_d = P_SKIP;
          end
        end
        P_SKIP: begin
          if (is_eol) begin
            pstate_d = P_ADDR;
            addr_d   = '0;
            data_d   = '0;
            ndig_d   = 1'b0;
          end
        end
        default: pstate_d = P_ADDR;
      endcase
    end
  end

  assign o_wr_strb = strb_q;
  assign o_wr_addr = wa_q;
  assign o_wr_data = wd_q;
  assign o_err     = err_q;

endmodule
